// File: rtl/wptr_full_stat.sv
// Write-domain pointer/status block for an async FIFO: binary and Gray write pointers, full,
// almost-full, fill level and sticky overflow. Optional drop counter under `WPTR_DROP_CNT_EN.
module wptr_full_stat #(
  parameter int ADDRSIZE    = 4,
  parameter int AFULL_LEVEL = 2
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  input  logic                wovf_clr,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wcount,
`ifdef WPTR_DROP_CNT_EN
  output logic [7:0]          wdrop_cnt,
`endif
  output logic                wovf
);

  localparam int PW    = ADDRSIZE + 1;
  localparam int DEPTH = 1 << ADDRSIZE;
  localparam logic [ADDRSIZE:0] AFULL_THRESH = PW'(DEPTH - AFULL_LEVEL);

  // Handshake: winc is a write request; a write is taken only in a cycle where wfull is low.
  // A request seen while wfull is high is dropped and recorded as an overflow.
  logic                wen;
  logic                drop;
  logic [ADDRSIZE:0]   wbin_q,   wbin_d;
  logic [ADDRSIZE:0]   wptr_q,   wptr_d;
  logic                wfull_q,  wfull_d;
  logic                wafull_q, wafull_d;
  logic [ADDRSIZE:0]   wcount_q, wcount_d;
  logic                wovf_q,   wovf_d;
  logic [ADDRSIZE:0]   rbin;

  assign wen  = winc & ~wfull_q;
  assign drop = winc & wfull_q;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rbin = '0;
    for (int i = 0; i <= ADDRSIZE; i++) begin
      rbin[i] = ^(wq2_rptr >> i);
    end
  end

  always_comb begin
    wbin_d   = wbin_q + PW'(wen);
    wptr_d   = (wbin_d >> 1) ^ wbin_d;
    wfull_d  = (wptr_d == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]});
    wcount_d = wbin_d - rbin;
    wafull_d = (wcount_d >= AFULL_THRESH);
    wovf_d   = drop | (wovf_q & ~wovf_clr);
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      wfull_q  <= 1'b0;
      wafull_q <= 1'b0;
      wcount_q <= '0;
      wovf_q   <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wptr_d;
      wfull_q  <= wfull_d;
      wafull_q <= wafull_d;
      wcount_q <= wcount_d;
      wovf_q   <= wovf_d;
    end
  end

`ifdef WPTR_DROP_CNT_EN
  logic [7:0] drop_q, drop_d;

  // A drop in the same cycle as a clear restarts the count at one.
  always_comb begin
    drop_d = drop_q;
    if (drop) begin
      if (wovf_clr)              drop_d = 8'd1;
      else if (drop_q != 8'hFF)  drop_d = drop_q + 8'd1;
    end else if (wovf_clr) begin
      drop_d = 8'd0;
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) drop_q <= 8'd0;
    else         drop_q <= drop_d;
  end

  assign wdrop_cnt = drop_q;
`endif

  assign waddr        = wbin_q[ADDRSIZE-1:0];
  assign wptr         = wptr_q;
  assign wfull        = wfull_q;
  assign walmost_full = wafull_q;
  assign wcount       = wcount_q;
  assign wovf         = wovf_q;

endmodule
